// File: rtl/ascon_pkg.sv
// Shared Ascon definitions: state layout, round constants and linear-layer rotations.
package ascon_pkg;

    localparam int ASCON_STATE_W    = 320;
    localparam int ASCON_LANE_W     = 64;
    localparam int ASCON_MAX_ROUNDS = 12;

    localparam int ROT_X0_A = 19;
    localparam int ROT_X0_B = 28;
    localparam int ROT_X1_A = 61;
    localparam int ROT_X1_B = 39;
    localparam int ROT_X2_A = 1;
    localparam int ROT_X2_B = 6;
    localparam int ROT_X3_A = 10;
    localparam int ROT_X3_B = 17;
    localparam int ROT_X4_A = 7;
    localparam int ROT_X4_B = 41;

    typedef logic [ASCON_LANE_W-1:0] lane_t;

    // x0 occupies the most significant lane, matching S[319:256]
    typedef struct packed {
        lane_t x0;
        lane_t x1;
        lane_t x2;
        lane_t x3;
        lane_t x4;
    } ascon_state_t;

    function automatic logic [7:0] rc(input logic [3:0] j);
        return {4'(4'd15 - j), j};
    endfunction

    function automatic lane_t ror(input lane_t x, input int n);
        return (x >> n) | (x << (ASCON_LANE_W - n));
    endfunction

endpackage

// File: rtl/ascon_permutation_if.sv
// Load/result bundle between an Ascon mode FSM (master) and the permutation core (slave).
interface ascon_permutation_if;
    import ascon_pkg::*;

    logic [ASCON_STATE_W-1:0] S;
    logic [4:0]               rounds;
    logic                     start;
    logic [ASCON_STATE_W-1:0] out;
    logic                     done;
    logic [4:0]               ctr;

    modport master (output S, rounds, start, input out, done, ctr);
    modport slave  (input S, rounds, start, output out, done, ctr);

endinterface

// File: rtl/ascon_round_counter.sv
// Round sequencer: latches the round count, steps ctr, flags completion and reloads.
// ASCON_PERM_TRACE_EN additionally exposes busy for the trace display.
module ascon_round_counter
    import ascon_pkg::*;
#(
    parameter int MAX_ROUNDS = ASCON_MAX_ROUNDS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] rounds,
`ifdef ASCON_PERM_TRACE_EN
    output logic       busy,
`endif
    output logic [4:0] ctr,
    output logic       done,
    output logic       load,
    output logic       step,
    output logic [3:0] rc_idx
);

    logic       busy_q, busy_d;
    logic [4:0] ctr_q, ctr_d;
    logic [4:0] r_q, r_d;
    logic [4:0] r_sat;
    logic [4:0] j_full;

    always_comb begin
        r_sat  = (rounds == 5'd0 || rounds > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : rounds;
        done   = busy_q && (ctr_q == r_q);
        // A start seen on the done cycle reloads without an idle bubble
        load   = start && (!busy_q || done);
        step   = busy_q && !done;
        j_full = 5'(MAX_ROUNDS) - r_q + ctr_q;
        rc_idx = j_full[3:0];

        busy_d = busy_q;
        ctr_d  = ctr_q;
        r_d    = r_q;
        if (load) begin
            busy_d = 1'b1;
            ctr_d  = 5'd0;
            r_d    = r_sat;
        end else if (step) begin
            ctr_d  = ctr_q + 5'd1;
        end else if (done) begin
            busy_d = 1'b0;
            ctr_d  = 5'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
            ctr_q  <= 5'd0;
            r_q    <= 5'd0;
        end else begin
            busy_q <= busy_d;
            ctr_q  <= ctr_d;
            r_q    <= r_d;
        end
    end

    assign ctr = ctr_q;
`ifdef ASCON_PERM_TRACE_EN
    assign busy = busy_q;
`endif

endmodule

// File: rtl/ascon_permutation.sv
// Iterative Ascon-p core: one round per clock, 1..12 rounds per invocation.
// Define ASCON_PERM_TRACE_EN for a per-edge simulation trace.
module ascon_permutation
    import ascon_pkg::*;
#(
    parameter int MAX_ROUNDS = ASCON_MAX_ROUNDS,
    parameter int W          = ASCON_LANE_W
) (
    input  logic                clk,
    input  logic                reset,
    ascon_permutation_if.slave  bus
);

    function automatic ascon_state_t ascon_round(input ascon_state_t s, input logic [3:0] j);
        lane_t x0, x1, x2, x3, x4;
        lane_t t0, t1, t2, t3, t4;
        ascon_state_t r;
        x0 = s.x0; x1 = s.x1; x2 = s.x2; x3 = s.x3; x4 = s.x4;
        x2 = x2 ^ {56'b0, rc(j)};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        r.x0 = x0 ^ ror(x0, ROT_X0_A) ^ ror(x0, ROT_X0_B);
        r.x1 = x1 ^ ror(x1, ROT_X1_A) ^ ror(x1, ROT_X1_B);
        r.x2 = x2 ^ ror(x2, ROT_X2_A) ^ ror(x2, ROT_X2_B);
        r.x3 = x3 ^ ror(x3, ROT_X3_A) ^ ror(x3, ROT_X3_B);
        r.x4 = x4 ^ ror(x4, ROT_X4_A) ^ ror(x4, ROT_X4_B);
        return r;
    endfunction

    logic [5*W-1:0] out_q, out_d;
    logic [4:0]     ctr;
    logic           done, load, step;
    logic [3:0]     rc_idx;
`ifdef ASCON_PERM_TRACE_EN
    logic           busy;
`endif

    ascon_round_counter #(.MAX_ROUNDS(MAX_ROUNDS)) u_ctr (
        .clk    (clk),
        .reset  (reset),
        .start  (bus.start),
        .rounds (bus.rounds),
`ifdef ASCON_PERM_TRACE_EN
        .busy   (busy),
`endif
        .ctr    (ctr),
        .done   (done),
        .load   (load),
        .step   (step),
        .rc_idx (rc_idx)
    );

    always_comb begin
        out_d = out_q;
        if (load)
            out_d = bus.S;
        else if (step)
            out_d = ascon_round(ascon_state_t'(out_q), rc_idx);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) out_q <= '0;
        else        out_q <= out_d;
    end

    assign bus.out  = out_q;
    assign bus.done = done;
    assign bus.ctr  = ctr;

`ifdef ASCON_PERM_TRACE_EN
    always @(posedge clk)
        $display("ascon_perm ctr=%h busy=%b done=%b start=%b out=%h",
                 ctr, busy, done, bus.start, out_q);
`endif

endmodule

// File: tb/tb_ascon_permutation.sv
// Directed bench for ascon_permutation with a table-driven S-box reference and a result scoreboard.
module tb_ascon_permutation;
    import ascon_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ascon_permutation_if bus();
    ascon_permutation dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    ascon_state_t exp_q[$];

    localparam logic [4:0] SBOX [0:31] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        logic [63:0] r;
        for (int b = 0; b < 64; b++) r[b] = x[(b + n) % 64];
        return r;
    endfunction

    function automatic ascon_state_t ref_round(input ascon_state_t s, input int j);
        logic [63:0] x [5];
        logic [4:0] o;
        ascon_state_t r;
        x[0] = s.x0; x[1] = s.x1; x[2] = s.x2; x[3] = s.x3; x[4] = s.x4;
        x[2][7:0] = x[2][7:0] ^ 8'(((15 - j) << 4) | j);
        for (int b = 0; b < 64; b++) begin
            o = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
            x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
        end
        r.x0 = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
        r.x1 = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
        r.x2 = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
        r.x3 = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
        r.x4 = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
        return r;
    endfunction

    function automatic ascon_state_t ref_perm(input ascon_state_t s, input int nr);
        ascon_state_t t = s;
        for (int i = 0; i < nr; i++) t = ref_round(t, 12 - nr + i);
        return t;
    endfunction

    function automatic ascon_state_t rand_state();
        logic [319:0] v;
        for (int k = 0; k < 10; k++) v[32*k +: 32] = $urandom;
        return ascon_state_t'(v);
    endfunction

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare the current result against the oldest expectation
    task automatic chk_pop(input string tag, output ascon_state_t exp);
        exp = '0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            exp = exp_q.pop_front();
            chk(tag, bus.out, exp);
        end
    endtask

    // Entered at the negedge following the load edge; returns the cycle count at done
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic finish_run(input string tag, input int nr);
        int cyc;
        ascon_state_t exp;
        wait_done(cyc);
        chk_i({tag, ":latency"}, cyc, nr + 1);
        chk_i({tag, ":ctr_at_done"}, int'(bus.ctr), nr);
        chk_pop({tag, ":result"}, exp);
        @(negedge clk);
        chk_i({tag, ":done_one_cycle"}, int'(bus.done), 0);
        chk_i({tag, ":ctr_idle"}, int'(bus.ctr), 0);
        chk({tag, ":out_hold"}, bus.out, exp);
    endtask

    task automatic run(input string tag, input ascon_state_t s, input logic [4:0] r, input int nr);
        bus.S = s;
        bus.rounds = r;
        bus.start = 1'b1;
        exp_q.push_back(ref_perm(s, nr));
        @(negedge clk);
        bus.start = 1'b0;
        bus.S = ~s;
        bus.rounds = 5'd3;
        finish_run(tag, nr);
    endtask

    initial begin
        ascon_state_t iv, s1, s2;
        ascon_state_t exp;
        int cyc;
        int n;
        iv.x0 = 64'h80400c0600000000;
        iv.x1 = 64'h0001020304050607;
        iv.x2 = 64'h08090a0b0c0d0e0f;
        iv.x3 = 64'h0001020304050607;
        iv.x4 = 64'h08090a0b0c0d0e0f;

        // Reset held with start asserted
        bus.S = iv;
        bus.rounds = 5'd12;
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset:out", bus.out, '0);
        chk_i("reset:done", int'(bus.done), 0);
        chk_i("reset:ctr", int'(bus.ctr), 0);
        reset = 1'b1;
        exp_q.push_back(ref_perm(iv, 12));
        @(negedge clk);
        bus.start = 1'b0;
        chk_i("iv:ctr_after_load", int'(bus.ctr), 0);
        chk("iv:out_after_load", bus.out, iv);
        finish_run("iv_p12", 12);

        run("p6", rand_state(), 5'd6, 6);
        run("r0_as_12", rand_state(), 5'd0, 12);
        run("r15_as_12", rand_state(), 5'd15, 12);
        run("r1", rand_state(), 5'd1, 1);
        run("r12", rand_state(), 5'd12, 12);

        // Back-to-back: start held through the run, new S presented on the done cycle
        s1 = rand_state();
        s2 = rand_state();
        bus.S = s1;
        bus.rounds = 5'd12;
        bus.start = 1'b1;
        exp_q.push_back(ref_perm(s1, 12));
        @(negedge clk);
        wait_done(cyc);
        chk_i("b2b:latency1", cyc, 13);
        chk_pop("b2b:result1", exp);
        bus.S = s2;
        exp_q.push_back(ref_perm(s2, 12));
        @(negedge clk);
        bus.start = 1'b0;
        chk_i("b2b:reload_ctr", int'(bus.ctr), 0);
        chk_i("b2b:reload_done", int'(bus.done), 0);
        chk("b2b:reload_out", bus.out, s2);
        finish_run("b2b2", 12);

        // Abort a run with reset at ctr=5
        s1 = rand_state();
        bus.S = s1;
        bus.rounds = 5'd12;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.ctr !== 5'd5 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk_i("abort:reached_ctr5", int'(bus.ctr), 5);
        reset = 1'b0;
        #1;
        chk("abort:out", bus.out, '0);
        chk_i("abort:ctr", int'(bus.ctr), 0);
        chk_i("abort:done", int'(bus.done), 0);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) n++;
        end
        chk_i("abort:no_done_pulse", n, 0);
        run("after_abort", rand_state(), 5'd12, 12);

        chk_i("scoreboard:drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
